// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: buffered
// multiply/divide entry layout and the per-cycle grant encoding.
package wb_arb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  reg_addr;
    logic [DATA_W-1:0] data;
  } md_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MD   = 2'd2,
    GNT_DROP = 2'd3
  } grant_e;

endpackage

// File: rtl/wb_md_fifo.sv
// Circular buffer of multiply/divide results. Entries whose destination is
// overwritten by a younger pipeline write are marked dead, not removed.
module wb_md_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_arb_pkg::md_entry_t    push_entry,
  input  logic                     pop,
  input  logic                     squash,
  input  logic [wb_arb_pkg::REG_W-1:0] squash_reg,
  output wb_arb_pkg::md_entry_t    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import wb_arb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  md_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage: a fresh push owns its slot; any other matching entry is killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {$bits(md_entry_t){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_r == PTR_W'(i))) begin
          mem_r[i] <= push_entry;
        end else if (squash && (mem_r[i].reg_addr == squash_reg)) begin
          mem_r[i].live <= 1'b0;
        end
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and
// buffered multiply/divide results, forcing a one-cycle stall on starvation.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   RegWrite_WB,
  input  logic [REG_W-1:0]       Write_Reg_WB,
  input  logic [DATA_W-1:0]      Write_Data_WB,
  input  logic                   MD_Valid,
  input  logic [REG_W-1:0]       MD_Reg,
  input  logic [DATA_W-1:0]      MD_Data,
  output logic                   MD_Ready,
  output logic                   RF_We,
  output logic [REG_W-1:0]       RF_Addr,
  output logic [DATA_W-1:0]      RF_Data,
  output logic                   Stall_Pipe,
  output logic [$clog2(DEPTH):0] Pending_Count
);
  import wb_arb_pkg::*;

  localparam int              SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT_C = SC_W'(STARVE_LIMIT);

  logic            p_req_s;
  logic            md_push_s;
  logic            md_keep_s;
  logic            pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  md_entry_t       head_s;
  md_entry_t       push_entry_s;
  grant_e          grant_s;
  logic [SC_W-1:0] starve_r;
  logic [SC_W-1:0] starve_next_s;
  logic            stall_r;

  // Request qualification, grant selection and next starvation count.
  always_comb begin
    p_req_s   = RegWrite_WB && (Write_Reg_WB != {REG_W{1'b0}}) && !stall_r;
    md_push_s = MD_Valid && !fifo_full_s;
    // Reg-0 results and results already superseded by this cycle's pipeline write are dropped.
    md_keep_s = md_push_s && (MD_Reg != {REG_W{1'b0}})
                && !(p_req_s && (MD_Reg == Write_Reg_WB));
    push_entry_s.live     = 1'b1;
    push_entry_s.reg_addr = MD_Reg;
    push_entry_s.data     = MD_Data;
    if (p_req_s) begin
      grant_s = GNT_PIPE;
    end else if (!fifo_empty_s) begin
      grant_s = head_s.live ? GNT_MD : GNT_DROP;
    end else begin
      grant_s = GNT_NONE;
    end
    pop_s = (grant_s == GNT_MD) || (grant_s == GNT_DROP);
    if (p_req_s && !fifo_empty_s) begin
      starve_next_s = starve_r + SC_W'(1);
    end else begin
      starve_next_s = {SC_W{1'b0}};
    end
  end

  wb_md_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (Clk),
    .rst        (Reset),
    .push       (md_keep_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .squash     (p_req_s),
    .squash_reg (Write_Reg_WB),
    .head       (head_s),
    .count      (Pending_Count),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // Registered write port, starvation counter and stall flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_r <= {SC_W{1'b0}};
      stall_r  <= 1'b0;
      RF_We    <= 1'b0;
      RF_Addr  <= {REG_W{1'b0}};
      RF_Data  <= {DATA_W{1'b0}};
    end else begin
      starve_r <= starve_next_s;
      stall_r  <= (starve_next_s == LIMIT_C);
      case (grant_s)
        GNT_PIPE: begin
          RF_We   <= 1'b1;
          RF_Addr <= Write_Reg_WB;
          RF_Data <= Write_Data_WB;
        end
        GNT_MD: begin
          RF_We   <= 1'b1;
          RF_Addr <= head_s.reg_addr;
          RF_Data <= head_s.data;
        end
        default: begin
          RF_We   <= 1'b0;
          RF_Addr <= {REG_W{1'b0}};
          RF_Data <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign MD_Ready   = !fifo_full_s;
  assign Stall_Pipe = stall_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: each task drives one scenario and
// compares the full output vector against hand-computed values.
module tb_wb_port_arbiter;

  logic        Clk;
  logic        Reset;
  logic        RegWrite_WB;
  logic [4:0]  Write_Reg_WB;
  logic [31:0] Write_Data_WB;
  logic        MD_Valid;
  logic [4:0]  MD_Reg;
  logic [31:0] MD_Data;
  logic        MD_Ready;
  logic        RF_We;
  logic [4:0]  RF_Addr;
  logic [31:0] RF_Data;
  logic        Stall_Pipe;
  logic [1:0]  Pending_Count;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .DATA_W(32), .REG_W(5)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .RegWrite_WB   (RegWrite_WB),
    .Write_Reg_WB  (Write_Reg_WB),
    .Write_Data_WB (Write_Data_WB),
    .MD_Valid      (MD_Valid),
    .MD_Reg        (MD_Reg),
    .MD_Data       (MD_Data),
    .MD_Ready      (MD_Ready),
    .RF_We         (RF_We),
    .RF_Addr       (RF_Addr),
    .RF_Data       (RF_Data),
    .Stall_Pipe    (Stall_Pipe),
    .Pending_Count (Pending_Count)
  );

  // Observed vector: {ready, stall, pending, we, addr, data}
  wire [41:0] obs = {MD_Ready, Stall_Pipe, Pending_Count, RF_We, RF_Addr, RF_Data};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [41:0] st(input logic rdy, input logic stall, input logic [1:0] cnt,
                                     input logic we, input logic [4:0] addr, input logic [31:0] data);
    return {rdy, stall, cnt, we, addr, data};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_p(input logic en, input logic [4:0] r, input logic [31:0] d);
    RegWrite_WB = en; Write_Reg_WB = r; Write_Data_WB = d;
  endtask

  task automatic set_md(input logic en, input logic [4:0] r, input logic [31:0] d);
    MD_Valid = en; MD_Reg = r; MD_Data = d;
  endtask

  task automatic test_reset();
    logic [41:0] exp;
    set_p(1'b0, 5'd0, 32'h0); set_md(1'b0, 5'd0, 32'h0);
    Reset = 1'b1;
    tick(); tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, exp); end
    checks++;
    Reset = 1'b0;
    tick();
    if (obs !== exp) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp); end
    checks++;
  endtask

  task automatic test_md_only();
    logic [41:0] exp;
    set_md(1'b1, 5'd8, 32'h1234);
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL md_push: got %h expected %h", obs, exp); end
    checks++;
    set_md(1'b0, 5'd0, 32'h0);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b1, 5'd8, 32'h1234);
    if (obs !== exp) begin errors++; $display("FAIL md_write: got %h expected %h", obs, exp); end
    checks++;
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL md_idle: got %h expected %h", obs, exp); end
    checks++;
  endtask

  task automatic test_pipe_priority();
    logic [41:0] exp;
    set_p(1'b1, 5'd3, 32'hAAAA); set_md(1'b1, 5'd9, 32'h9999);
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b1, 5'd3, 32'hAAAA);
    if (obs !== exp) begin errors++; $display("FAIL pipe_first: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b0, 5'd0, 32'h0); set_md(1'b0, 5'd0, 32'h0);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b1, 5'd9, 32'h9999);
    if (obs !== exp) begin errors++; $display("FAIL md_after_pipe: got %h expected %h", obs, exp); end
    checks++;
  endtask

  task automatic test_squash();
    logic [41:0] exp;
    set_md(1'b1, 5'd5, 32'h5555);
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL squash_buffered: got %h expected %h", obs, exp); end
    checks++;
    set_md(1'b0, 5'd0, 32'h0); set_p(1'b1, 5'd5, 32'hBEEF);
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b1, 5'd5, 32'hBEEF);
    if (obs !== exp) begin errors++; $display("FAIL squash_pipe_write: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b0, 5'd0, 32'h0);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL squash_dead_pop: got %h expected %h", obs, exp); end
    checks++;
    tick();
    if (obs !== exp) begin errors++; $display("FAIL squash_no_late_write: got %h expected %h", obs, exp); end
    checks++;
  endtask

  task automatic test_zero_and_same_reg();
    logic [41:0] exp;
    set_p(1'b1, 5'd0, 32'hCAFE); set_md(1'b1, 5'd0, 32'hDEAD);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL reg0_ignored: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b1, 5'd4, 32'h4444); set_md(1'b1, 5'd4, 32'h0404);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b1, 5'd4, 32'h4444);
    if (obs !== exp) begin errors++; $display("FAIL same_reg_discard: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b0, 5'd0, 32'h0); set_md(1'b0, 5'd0, 32'h0);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL same_reg_no_md: got %h expected %h", obs, exp); end
    checks++;
  endtask

  task automatic test_starvation();
    logic [41:0] exp;
    set_p(1'b1, 5'd1, 32'h101); set_md(1'b1, 5'd7, 32'h7777);
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b1, 5'd1, 32'h101);
    if (obs !== exp) begin errors++; $display("FAIL starve_setup: got %h expected %h", obs, exp); end
    checks++;
    set_md(1'b0, 5'd0, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      set_p(1'b1, 5'(k), 32'h100 + 32'(k));
      tick();
      exp = st(1'b1, (k == 5), 2'd1, 1'b1, 5'(k), 32'h100 + 32'(k));
      if (obs !== exp) begin errors++; $display("FAIL starve_cycle%0d: got %h expected %h", k, obs, exp); end
      checks++;
    end
    set_p(1'b1, 5'd6, 32'h106);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b1, 5'd7, 32'h7777);
    if (obs !== exp) begin errors++; $display("FAIL starve_forced_drain: got %h expected %h", obs, exp); end
    checks++;
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b1, 5'd6, 32'h106);
    if (obs !== exp) begin errors++; $display("FAIL starve_held_write: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b0, 5'd0, 32'h0);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL starve_idle: got %h expected %h", obs, exp); end
    checks++;
  endtask

  task automatic test_full();
    logic [41:0] exp;
    set_p(1'b1, 5'd1, 32'h201); set_md(1'b1, 5'd10, 32'hA0);
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b1, 5'd1, 32'h201);
    if (obs !== exp) begin errors++; $display("FAIL full_push1: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b1, 5'd2, 32'h202); set_md(1'b1, 5'd11, 32'hB0);
    tick();
    exp = st(1'b0, 1'b0, 2'd2, 1'b1, 5'd2, 32'h202);
    if (obs !== exp) begin errors++; $display("FAIL full_push2: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b1, 5'd3, 32'h203); set_md(1'b1, 5'd12, 32'hC0);
    tick();
    exp = st(1'b0, 1'b0, 2'd2, 1'b1, 5'd3, 32'h203);
    if (obs !== exp) begin errors++; $display("FAIL full_held: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b0, 5'd0, 32'h0);
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b1, 5'd10, 32'hA0);
    if (obs !== exp) begin errors++; $display("FAIL full_pop1: got %h expected %h", obs, exp); end
    checks++;
    tick();
    exp = st(1'b1, 1'b0, 2'd1, 1'b1, 5'd11, 32'hB0);
    if (obs !== exp) begin errors++; $display("FAIL full_push_pop: got %h expected %h", obs, exp); end
    checks++;
    set_md(1'b0, 5'd0, 32'h0);
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b1, 5'd12, 32'hC0);
    if (obs !== exp) begin errors++; $display("FAIL full_third: got %h expected %h", obs, exp); end
    checks++;
    tick();
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL full_idle: got %h expected %h", obs, exp); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [41:0] exp;
    set_p(1'b1, 5'd1, 32'h301); set_md(1'b1, 5'd20, 32'h14);
    tick();
    set_p(1'b1, 5'd2, 32'h302); set_md(1'b1, 5'd21, 32'h15);
    tick();
    set_md(1'b0, 5'd0, 32'h0);
    for (int k = 3; k <= 5; k++) begin
      set_p(1'b1, 5'(k), 32'h300 + 32'(k));
      tick();
    end
    exp = st(1'b0, 1'b1, 2'd2, 1'b1, 5'd5, 32'h305);
    if (obs !== exp) begin errors++; $display("FAIL mid_pre_reset: got %h expected %h", obs, exp); end
    checks++;
    Reset = 1'b1;
    #1;
    exp = st(1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    if (obs !== exp) begin errors++; $display("FAIL mid_async_reset: got %h expected %h", obs, exp); end
    checks++;
    set_p(1'b0, 5'd0, 32'h0);
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (obs !== exp) begin errors++; $display("FAIL mid_after_release%0d: got %h expected %h", k, obs, exp); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_md_only();
    test_pipe_priority();
    test_squash();
    test_zero_and_same_reg();
    test_starvation();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
